rtype_seq_ctrl: RTL and testbench
=================================

# rtype_seq_ctrl

Multi-cycle sequencer for the R-type RISC-V datapath. It owns the instruction register and drives the PC, register file and ALU one phase at a time. Instruction memory is accessed through a req/ack handshake, so variable-latency memories can replace the zero-wait IMEM. It replaces the purely combinational controller when the core runs as a multi-cycle machine, and sits between IMEM, the PC register, the register file and the ALU.

## Interface
Parameters:
- XLEN, 32, datapath/instruction width
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  reset, synchronous, active-low
- run  in  1  1 = fetch new instructions; 0 = finish current instruction then idle in FETCH
- imem_req  out  1  fetch request, held until ack
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  XLEN  fetched instruction
- pc_we  out  1  one-cycle pulse: PC <= PC + 4
- rs1  out  5  IR[19:15]
- rs2  out  5  IR[24:20]
- rd  out  5  IR[11:7]
- alu_sel  out  4  ALU operation code (package encoding)
- reg_wen  out  1  register-file write enable, one cycle
- trap  out  1  sticky illegal-instruction flag
- busy  out  1  1 in any state other than idle FETCH
- cycle_cnt  out  CNT_W  cycles since reset (RTYPE_PERF_CNT_EN)
- instret_cnt  out  CNT_W  retired instructions (RTYPE_PERF_CNT_EN)

## Operation
- FSM states: FETCH, DECODE, EXEC, WB, TRAP.
- FETCH:
  - imem_req = run.
  - On imem_req && imem_ack: IR <= imem_rdata, go to DECODE.
  - If run falls while a request is outstanding, imem_req stays high until ack. The request is never abandoned.
- DECODE: the rtype_decoder result is registered into alu_sel and an illegal bit.
  - If illegal: go to TRAP.
  - Otherwise go to EXEC.
- EXEC: one cycle for register-file read and ALU settle. No outputs pulse.
- WB:
  - reg_wen = (rd != 0).
  - pc_we = 1.
  - instret_cnt++.
  - Go to FETCH.
- TRAP:
  - trap = 1, reg_wen = 0, pc_we = 0, imem_req = 0.
  - Left only by reset.
- Legal instructions are those with opcode 0110011 and one of:
  - funct7 = 0000000 with any funct3, or
  - funct7 = 0100000 with funct3 ∈ {000, 101}.
  - Everything else is illegal.
- alu_sel encoding:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - 10–15 are unused and never produced.
- Writes to rd = x0 are suppressed by this block; the register file is not relied upon to do it.
- busy = 0 only in FETCH with imem_req = 0. busy = 1 in TRAP.

## Timing
- Reset values:
  - state FETCH; IR = 32'h0000_0033.
  - alu_sel = 0; imem_req = 0; pc_we = 0; reg_wen = 0; trap = 0; busy = 0.
  - Both counters 0.
- imem_req is Moore. It rises the cycle after rst deasserts, if run = 1.
- Latency: ack in the same cycle as req gives 4 cycles per instruction (FETCH, DECODE, EXEC, WB). Each extra wait cycle adds 1.
- rs1/rs2/rd are combinational from IR and valid from DECODE onward. alu_sel is valid from EXEC onward.
- pc_we and reg_wen assert in the same cycle (WB). The PC increments and rd is written on the same edge.
- imem_ack while imem_req = 0 is ignored.
- rst low in any state, including mid-handshake or TRAP, returns the block to reset values on the next edge. The outstanding request is dropped.
- Counters wrap modulo 2^CNT_W without flag.
  - cycle_cnt increments every cycle after reset, including TRAP.
  - instret_cnt increments only in WB.

## Configuration
- RTYPE_PERF_CNT_EN defined: cycle_cnt and instret_cnt are implemented as described.
- RTYPE_PERF_CNT_EN undefined: the counter ports remain but are tied to 0, and no counter flops are inferred.

## Structure
- Package riscv_rtype_pkg contains:
  - ALU op localparams (ALU_ADD … ALU_AND);
  - OPC_RTYPE = 7'b0110011;
  - FUNCT7_BASE and FUNCT7_ALT;
  - the FSM state encoding.
- Sub-module rtype_decoder:
  - combinational, IR → {alu_sel, illegal};
  - reusable by the single-cycle controller.
- Top-level register flops: IR, state, alu_sel, trap, counters.

## Test plan
- Zero-wait stream: run = 1, acks same cycle; program is add x3,x1,x2 (0x002081B3) then sub x4,x1,x2 (0x40208233).
  - pc_we pulses at cycles 4 and 8; reg_wen at the same cycles.
  - alu_sel = 0, then 1; rd = 3, then 4; instret_cnt = 2.
- Wait states: ack delayed 3 cycles on 0x0020F1B3 (and).
  - imem_req held 4 cycles.
  - WB at cycle 7; alu_sel = 9.
- x0 destination: 0x00208033 (add x0,x1,x2).
  - reg_wen stays 0 in WB; pc_we = 1; instret_cnt increments.
- Illegal instructions: 0x00000013 (addi), and 0x40209033 (funct7 alt with funct3 001).
  - trap = 1 from the cycle after DECODE; no pc_we or reg_wen.
  - trap is held until rst is low for one edge.
- Run drop and reset: run falls during an outstanding req.
  - req is held until ack; the instruction completes; the block idles with busy = 0.
  - rst low mid-EXEC gives all reset values the next cycle and cycle_cnt = 0.

Source files
------------

// File: rtl/riscv_rtype_pkg.sv
// Shared definitions for the R-type RISC-V controllers: ALU operation codes,
// opcode/funct7 constants, sequencer state encoding and instruction reset value.
package riscv_rtype_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   // add x0,x0,x0: a harmless legal instruction held in IR out of reset
   localparam logic [31:0] IR_RESET = 32'h0000_0033;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_TRAP   = 3'd4
   } state_t;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decoder: instruction fields -> ALU op and illegal flag.
// Shared between the multi-cycle sequencer and the single-cycle controller.
module rtype_decoder
   import riscv_rtype_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_sel,
   output logic       illegal
);

   // Map funct3/funct7 to an ALU op; anything not recognised is illegal
   always_comb begin
      alu_sel = ALU_ADD;
      illegal = 1'b1;
      if (opcode == OPC_RTYPE) begin
         if (funct7 == FUNCT7_BASE) begin
            illegal = 1'b0;
            case (funct3)
               3'b000:  alu_sel = ALU_ADD;
               3'b001:  alu_sel = ALU_SLL;
               3'b010:  alu_sel = ALU_SLT;
               3'b011:  alu_sel = ALU_SLTU;
               3'b100:  alu_sel = ALU_XOR;
               3'b101:  alu_sel = ALU_SRL;
               3'b110:  alu_sel = ALU_OR;
               default: alu_sel = ALU_AND;
            endcase
         end else if (funct7 == FUNCT7_ALT) begin
            case (funct3)
               3'b000: begin
                  alu_sel = ALU_SUB;
                  illegal = 1'b0;
               end
               3'b101: begin
                  alu_sel = ALU_SRA;
                  illegal = 1'b0;
               end
               default: begin
                  alu_sel = ALU_ADD;
                  illegal = 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/rtype_seq_ctrl.sv
// Multi-cycle R-type sequencer: FETCH -> DECODE -> EXEC -> WB, with an
// IMEM req/ack handshake and a sticky TRAP state for illegal instructions.
// Optional feature macro: RTYPE_PERF_CNT_EN enables the cycle/instret counters;
// without it the counter ports are tied to zero.
module rtype_seq_ctrl
   import riscv_rtype_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [XLEN-1:0]  imem_rdata,
   output logic             pc_we,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [3:0]       alu_sel,
   output logic             reg_wen,
   output logic             trap,
   output logic             busy,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   state_t            state;
   state_t            state_nxt;
   logic              req_q;
   logic              req_nxt;
   logic [XLEN-1:0]   ir;
   logic [3:0]        dec_alu_sel;
   logic              dec_illegal;

   rtype_decoder u_dec (
      .opcode  (ir[6:0]),
      .funct3  (ir[14:12]),
      .funct7  (ir[31:25]),
      .alu_sel (dec_alu_sel),
      .illegal (dec_illegal)
   );

   assign rs1 = ir[19:15];
   assign rs2 = ir[24:20];
   assign rd  = ir[11:7];

   // The request flop only ever holds 1 in FETCH, so it is the Moore request
   assign imem_req = req_q;
   assign busy     = (state != ST_FETCH) || req_q;

   // State and request registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_FETCH;
         req_q <= 1'b0;
      end else begin
         state <= state_nxt;
         req_q <= req_nxt;
      end
   end

   // Next state, next request, and the WB strobes
   always_comb begin
      state_nxt = state;
      req_nxt   = 1'b0;
      pc_we     = 1'b0;
      reg_wen   = 1'b0;
      case (state)
         ST_FETCH: begin
            if (req_q) begin
               // an issued request is held until ack even if run drops
               if (imem_ack) begin
                  state_nxt = ST_DECODE;
               end else begin
                  req_nxt = 1'b1;
               end
            end else begin
               req_nxt = run;
            end
         end
         ST_DECODE: state_nxt = dec_illegal ? ST_TRAP : ST_EXEC;
         ST_EXEC:   state_nxt = ST_WB;
         ST_WB: begin
            pc_we     = 1'b1;
            reg_wen   = (rd != 5'd0);
            req_nxt   = run;
            state_nxt = ST_FETCH;
         end
         ST_TRAP:   state_nxt = ST_TRAP;
         default:   state_nxt = ST_FETCH;
      endcase
   end

   // Instruction register, registered decode result and sticky trap flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         ir      <= XLEN'(IR_RESET);
         alu_sel <= ALU_ADD;
         trap    <= 1'b0;
      end else begin
         if ((state == ST_FETCH) && req_q && imem_ack) begin
            ir <= imem_rdata;
         end
         if (state == ST_DECODE) begin
            alu_sel <= dec_alu_sel;
            if (dec_illegal) begin
               trap <= 1'b1;
            end
         end
      end
   end

`ifdef RTYPE_PERF_CNT_EN
   // Free-running cycle counter and retired-instruction counter, both wrapping
   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (state == ST_WB) begin
            instret_cnt <= instret_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_rtype_seq_ctrl.sv
// Directed bench for rtype_seq_ctrl: zero-wait stream, wait states, x0
// destination, illegal instructions, run drop and reset during EXEC.
module tb_rtype_seq_ctrl;

`ifdef RTYPE_PERF_CNT_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        pc_we;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [3:0]  alu_sel;
   logic        reg_wen;
   logic        trap;
   logic        busy;
   logic [31:0] cycle_cnt;
   logic [31:0] instret_cnt;

   int n_vec = 0;
   int n_err = 0;

   rtype_seq_ctrl #(.XLEN(32), .CNT_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .imem_req    (imem_req),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .pc_we       (pc_we),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd          (rd),
      .alu_sel     (alu_sel),
      .reg_wen     (reg_wen),
      .trap        (trap),
      .busy        (busy),
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] perf(input int n);
      return 32'(PERF * n);
   endfunction

   initial begin
      rst = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
      step(); step();
      chk("rst_req",     32'(imem_req), 32'd0);
      chk("rst_pc_we",   32'(pc_we),    32'd0);
      chk("rst_reg_wen", 32'(reg_wen),  32'd0);
      chk("rst_trap",    32'(trap),     32'd0);
      chk("rst_busy",    32'(busy),     32'd0);
      chk("rst_alu_sel", 32'(alu_sel),  32'd0);
      chk("rst_rd",      32'(rd),       32'd0);
      chk("rst_rs1",     32'(rs1),      32'd0);
      chk("rst_cycle",   cycle_cnt,     32'd0);
      chk("rst_instret", instret_cnt,   32'd0);

      // zero-wait stream: add x3,x1,x2 then sub x4,x1,x2
      rst = 1'b1; run = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h002081B3;
      step();                                   // cycle 1 FETCH
      chk("a_c1_req",   32'(imem_req), 32'd1);
      chk("a_c1_busy",  32'(busy),     32'd1);
      chk("a_c1_cycle", cycle_cnt,     perf(1));
      step();                                   // cycle 2 DECODE
      imem_ack = 1'b0;
      chk("a_c2_req",   32'(imem_req), 32'd0);
      chk("a_c2_rd",    32'(rd),       32'd3);
      chk("a_c2_rs1",   32'(rs1),      32'd1);
      chk("a_c2_rs2",   32'(rs2),      32'd2);
      chk("a_c2_pc_we", 32'(pc_we),    32'd0);
      step();                                   // cycle 3 EXEC
      chk("a_c3_alu",   32'(alu_sel),  32'd0);
      chk("a_c3_pc_we", 32'(pc_we),    32'd0);
      imem_ack = 1'b1; imem_rdata = 32'h40208233;
      step();                                   // cycle 4 WB
      chk("a_c4_pc_we", 32'(pc_we),    32'd1);
      chk("a_c4_wen",   32'(reg_wen),  32'd1);
      step();                                   // cycle 5 FETCH
      chk("a_c5_req",   32'(imem_req), 32'd1);
      chk("a_c5_pc_we", 32'(pc_we),    32'd0);
      step();                                   // cycle 6 DECODE
      imem_ack = 1'b0;
      chk("a_c6_rd",    32'(rd),       32'd4);
      step();                                   // cycle 7 EXEC
      chk("a_c7_alu",   32'(alu_sel),  32'd1);
      chk("a_c7_wen",   32'(reg_wen),  32'd0);
      step();                                   // cycle 8 WB
      chk("a_c8_pc_we", 32'(pc_we),    32'd1);
      chk("a_c8_wen",   32'(reg_wen),  32'd1);
      chk("a_c8_cycle", cycle_cnt,     perf(8));
      chk("a_c8_inst",  instret_cnt,   perf(1));
      run = 1'b0;
      step();                                   // cycle 9 idle FETCH
      chk("a_c9_inst",  instret_cnt,   perf(2));
      chk("a_c9_busy",  32'(busy),     32'd0);
      chk("a_c9_req",   32'(imem_req), 32'd0);

      // wait states: and x3,x1,x2 with ack in the 4th request cycle
      rst = 1'b0;
      step();
      chk("b_rst_cycle", cycle_cnt,    32'd0);
      rst = 1'b1; run = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0020F1B3;
      step();
      chk("b_c1_req",   32'(imem_req), 32'd1);
      step();
      chk("b_c2_req",   32'(imem_req), 32'd1);
      step();
      chk("b_c3_req",   32'(imem_req), 32'd1);
      step();
      chk("b_c4_req",   32'(imem_req), 32'd1);
      imem_ack = 1'b1;
      step();                                   // cycle 5 DECODE
      imem_ack = 1'b0;
      chk("b_c5_req",   32'(imem_req), 32'd0);
      chk("b_c5_rd",    32'(rd),       32'd3);
      step();                                   // cycle 6 EXEC
      chk("b_c6_alu",   32'(alu_sel),  32'd9);
      chk("b_c6_pc_we", 32'(pc_we),    32'd0);
      step();                                   // cycle 7 WB
      chk("b_c7_pc_we", 32'(pc_we),    32'd1);
      chk("b_c7_wen",   32'(reg_wen),  32'd1);
      chk("b_c7_cycle", cycle_cnt,     perf(7));
      run = 1'b0;
      step();
      chk("b_idle_busy", 32'(busy),    32'd0);
      chk("b_inst",     instret_cnt,   perf(1));

      // x0 destination: write suppressed, PC still advances
      run = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h00208033;
      step();
      chk("c_req",      32'(imem_req), 32'd1);
      step();
      imem_ack = 1'b0;
      chk("c_rd",       32'(rd),       32'd0);
      step();
      step();
      chk("c_wb_pc_we", 32'(pc_we),    32'd1);
      chk("c_wb_wen",   32'(reg_wen),  32'd0);
      run = 1'b0;
      step();
      chk("c_inst",     instret_cnt,   perf(2));

      // illegal addi: sticky trap until reset
      run = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h00000013;
      step();                                   // FETCH
      step();                                   // DECODE
      chk("d_dec_trap", 32'(trap),     32'd0);
      step();                                   // TRAP
      chk("d_trap",     32'(trap),     32'd1);
      chk("d_busy",     32'(busy),     32'd1);
      chk("d_req",      32'(imem_req), 32'd0);
      chk("d_pc_we",    32'(pc_we),    32'd0);
      chk("d_wen",      32'(reg_wen),  32'd0);
      step(); step();
      chk("d_hold_trap", 32'(trap),    32'd1);
      chk("d_hold_req", 32'(imem_req), 32'd0);
      chk("d_hold_pc",  32'(pc_we),    32'd0);
      chk("d_inst",     instret_cnt,   perf(2));
      rst = 1'b0;
      step();
      chk("d_rst_trap", 32'(trap),     32'd0);
      chk("d_rst_busy", 32'(busy),     32'd0);

      // illegal: funct7 alt with funct3 001
      rst = 1'b1; run = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h40209033;
      step();
      step();
      step();
      chk("e_trap",     32'(trap),     32'd1);
      chk("e_pc_we",    32'(pc_we),    32'd0);
      chk("e_wen",      32'(reg_wen),  32'd0);
      rst = 1'b0;
      step();
      chk("e_rst_trap", 32'(trap),     32'd0);

      // run drop with an outstanding request
      rst = 1'b1; run = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0020F1B3;
      step();
      chk("f_c1_req",   32'(imem_req), 32'd1);
      run = 1'b0;
      step();
      chk("f_c2_req",   32'(imem_req), 32'd1);
      step();
      chk("f_c3_req",   32'(imem_req), 32'd1);
      imem_ack = 1'b1;
      step();                                   // DECODE
      imem_ack = 1'b0;
      chk("f_dec_req",  32'(imem_req), 32'd0);
      step();                                   // EXEC
      chk("f_alu",      32'(alu_sel),  32'd9);
      step();                                   // WB
      chk("f_pc_we",    32'(pc_we),    32'd1);
      step();
      chk("f_idle_busy", 32'(busy),    32'd0);
      chk("f_idle_req", 32'(imem_req), 32'd0);

      // ignored ack while idle, then reset in the middle of EXEC
      imem_ack = 1'b1; imem_rdata = 32'h40208233;
      step();
      chk("g_ign_busy", 32'(busy),     32'd0);
      chk("g_ign_rd",   32'(rd),       32'd3);
      run = 1'b1;
      step();                                   // FETCH with request
      step();                                   // DECODE
      imem_ack = 1'b0;
      step();                                   // EXEC
      chk("g_exec_alu", 32'(alu_sel),  32'd1);
      chk("g_exec_busy", 32'(busy),    32'd1);
      rst = 1'b0;
      step();
      chk("g_rst_alu",  32'(alu_sel),  32'd0);
      chk("g_rst_busy", 32'(busy),     32'd0);
      chk("g_rst_req",  32'(imem_req), 32'd0);
      chk("g_rst_rd",   32'(rd),       32'd0);
      chk("g_rst_cyc",  cycle_cnt,     32'd0);
      chk("g_rst_inst", instret_cnt,   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
